regbank_readout: RTL and testbench

Button-stepped readout controller that lets the board user inspect any register of `regbank` on the 16-bit LED bank, as the read-side counterpart to the switch/button write-and-compute sequencer. It drives one `regbank` read-address port, captures the 32-bit read data, and shows it as two 16-bit halves, LSB first. It debounces the push button internally and supports an auto-increment scan mode for walking the register file.

---
 rtl/regbank_readout_if.sv | 8 +
 rtl/regbank_readout.sv | 112 +++++++++++
 tb/tb_regbank_readout.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regbank_readout_if.sv
// Read port between the readout controller and regbank: address out, 32-bit data back.
interface regbank_readout_if;
  logic [4:0]  rd_sel;
  logic [31:0] rd_data;

  modport master (output rd_sel, input rd_data);
  modport slave  (input rd_sel, output rd_data);
endinterface

// File: rtl/regbank_readout.sv
// Button-stepped regbank readout: debounced button walks address echo, fetch,
// low half and high half of a 32-bit register on the 16-bit LED bank.
module regbank_readout #(
  parameter int DB_CYCLES = 1000000,
  parameter int DB_W      = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         in,
  input  logic                btn,
  regbank_readout_if.master   rb,
  output logic [15:0]         out,
  output logic                hi_half
);

  typedef enum logic [1:0] {S_ADDR, S_FETCH, S_LO, S_HI} state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES);

  logic            sync_p0, sync_p1;
  logic            db, db_p2, press;
  logic [DB_W-1:0] cnt;

  state_t      state;
  logic [4:0]  addr, rd_sel;
  logic        scan;
  logic [31:0] data_q;

  logic unused_in;
  assign unused_in = ^in[14:5];

  assign rb.rd_sel = rd_sel;

  // Button path: 2-flop synchronizer, debounce counter, rising-edge pulse.
  // The toggle fires on the edge after cnt has counted DB_CYCLES mismatching
  // samples, which puts db at edge DB_CYCLES+2 from the first high sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      db      <= 1'b0;
      db_p2   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      if (sync_p1 == db) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        db  <= ~db;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      db_p2 <= db;
      press <= db & ~db_p2;
    end
  end

  // Readout sequencer; rd_sel is set one edge ahead of the S_FETCH sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_ADDR;
      out     <= '0;
      rd_sel  <= '0;
      hi_half <= 1'b0;
      addr    <= '0;
      scan    <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state)
        S_ADDR: begin
          out <= {11'b0, in[4:0]};
          if (press) begin
            addr   <= in[4:0];
            rd_sel <= in[4:0];
            scan   <= in[15];
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          data_q  <= rb.rd_data;
          out     <= rb.rd_data[15:0];
          hi_half <= 1'b0;
          state   <= S_LO;
        end
        S_LO: begin
          if (press) begin
            out     <= data_q[31:16];
            hi_half <= 1'b1;
            state   <= S_HI;
          end
        end
        S_HI: begin
          if (press) begin
            if (scan) begin
              addr   <= addr + 5'd1;
              rd_sel <= addr + 5'd1;
              state  <= S_FETCH;
            end else begin
              hi_half <= 1'b0;
              state   <= S_ADDR;
            end
          end
        end
        default: state <= S_ADDR;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_readout.sv
// Bench for regbank_readout: vector table, hand-written corner sequences and
// randomized presses checked against a press-level behavioural model.
module tb_regbank_readout;
  localparam int DB_CYCLES = 4;
  localparam int DB_W      = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn = 1'b0;
  logic [15:0] in = 16'h0000;
  logic [15:0] out;
  logic        hi_half;
  logic [31:0] regs [32];

  regbank_readout_if rb();
  assign rb.rd_data = regs[rb.rd_sel];

  regbank_readout #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .btn     (btn),
    .rb      (rb),
    .out     (out),
    .hi_half (hi_half)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Press-level model: 0 = showing address echo, 1 = low half, 2 = high half.
  int          m_phase = 0;
  logic [4:0]  m_addr = 5'd0;
  logic        m_scan = 1'b0;
  logic [31:0] m_data = 32'h0;
  logic [15:0] m_out = 16'h0;
  logic        m_hi = 1'b0;

  typedef struct {
    logic [15:0] sw;
    logic [31:0] val;
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
    logic [15:0] exp_echo;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [15:0] v);
    in = v;
    if (m_phase == 0) m_out = {11'b0, v[4:0]};
  endtask

  task automatic model_press();
    case (m_phase)
      0: begin
        m_addr  = in[4:0];
        m_scan  = in[15];
        m_data  = regs[m_addr];
        m_out   = m_data[15:0];
        m_hi    = 1'b0;
        m_phase = 1;
      end
      1: begin
        m_out   = m_data[31:16];
        m_hi    = 1'b1;
        m_phase = 2;
      end
      default: begin
        if (m_scan) begin
          m_addr  = m_addr + 5'd1;
          m_data  = regs[m_addr];
          m_out   = m_data[15:0];
          m_hi    = 1'b0;
          m_phase = 1;
        end else begin
          m_hi    = 1'b0;
          m_out   = {11'b0, in[4:0]};
          m_phase = 0;
        end
      end
    endcase
  endtask

  task automatic do_press();
    btn = 1'b1;
    repeat (12) @(negedge clk);
    btn = 1'b0;
    repeat (12) @(negedge clk);
    model_press();
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out"}, out, m_out);
    check({tag, ".hi_half"}, hi_half, m_hi);
    check({tag, ".rd_sel"}, rb.rd_sel, m_addr);
  endtask

  task automatic do_reset(input logic [15:0] sw);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_async.out", out, 16'h0000);
    check("rst_async.hi_half", hi_half, 1'b0);
    check("rst_async.rd_sel", rb.rd_sel, 5'd0);
    @(negedge clk);
    in = sw;
    reset = 1'b1;
    m_phase = 0; m_addr = 5'd0; m_scan = 1'b0; m_hi = 1'b0;
    m_out = {11'b0, sw[4:0]};
    @(negedge clk);
    check("rst_release.echo", out, m_out);
  endtask

  initial begin
    logic [15:0] scan_out [6];
    logic [4:0]  scan_sel [6];
    logic        scan_hi  [6];
    int          scan_cnt;

    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    vecs[0] = '{16'h0005, 32'h1234ABCD, 16'hABCD, 16'h1234, 16'h0005};
    vecs[1] = '{16'h001F, 32'hDEADBEEF, 16'hBEEF, 16'hDEAD, 16'h001F};
    vecs[2] = '{16'h7FE0, 32'hCAFE0001, 16'h0001, 16'hCAFE, 16'h0000};
    vecs[3] = '{16'h0010, 32'h80000000, 16'h0000, 16'h8000, 16'h0010};
    scan_out = '{16'h001E, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000};
    scan_sel = '{5'd30, 5'd30, 5'd31, 5'd31, 5'd0, 5'd0};
    scan_hi  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state while held, then echo on first edge after release.
    #12;
    check("reset.out", out, 16'h0000);
    check("reset.hi_half", hi_half, 1'b0);
    check("reset.rd_sel", rb.rd_sel, 5'd0);
    @(negedge clk);
    in = 16'h0007;
    reset = 1'b1;
    m_out = 16'h0007;
    @(negedge clk);
    check("reset.first_echo", out, 16'h0007);

    // Table of single reads: low half, high half, back to echo.
    for (int i = 0; i < 4; i++) begin
      regs[vecs[i].sw[4:0]] = vecs[i].val;
      set_in(vecs[i].sw);
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d.echo0", i), out, vecs[i].exp_echo);
      do_press();
      check($sformatf("vec%0d.lo", i), out, vecs[i].exp_lo);
      check($sformatf("vec%0d.lo_flag", i), hi_half, 1'b0);
      check($sformatf("vec%0d.rd_sel", i), rb.rd_sel, vecs[i].sw[4:0]);
      do_press();
      check($sformatf("vec%0d.hi", i), out, vecs[i].exp_hi);
      check($sformatf("vec%0d.hi_flag", i), hi_half, 1'b1);
      do_press();
      check($sformatf("vec%0d.echo", i), out, vecs[i].exp_echo);
      check($sformatf("vec%0d.back_flag", i), hi_half, 1'b0);
    end

    // Bouncy pulses must not advance; a steady hold gives one press at edge 7.
    regs[9] = 32'hA5A55A5A;
    set_in(16'h0009);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      btn = 1'b1;
      repeat (3) @(negedge clk);
      btn = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check("bounce.out", out, 16'h0009);
    check("bounce.hi_half", hi_half, 1'b0);
    btn = 1'b1;
    repeat (9) @(negedge clk);
    check("hold.before_fetch", out, 16'h0009);
    @(negedge clk);
    check("hold.after_fetch", out, 16'h5A5A);
    repeat (30) @(negedge clk);
    btn = 1'b0;
    repeat (12) @(negedge clk);
    check("hold.single_advance", out, 16'h5A5A);
    check("hold.single_flag", hi_half, 1'b0);
    model_press();
    do_press();
    do_press();
    check_model("hold.return");

    // Captured data is not refreshed by a later register write.
    regs[3] = 32'h11112222;
    set_in(16'h0003);
    do_press();
    check("stale.lo", out, 16'h2222);
    regs[3] = 32'h33334444;
    do_press();
    check("stale.hi", out, 16'h1111);
    do_press();

    // Switches are ignored outside the address state.
    regs[4] = 32'hBEEF0042;
    set_in(16'h0004);
    do_press();
    for (int k = 0; k < 8; k++) begin
      set_in(16'($urandom));
      @(negedge clk);
    end
    check("iso.out", out, 16'h0042);
    check("iso.rd_sel", rb.rd_sel, 5'd4);
    do_press();
    check("iso.hi", out, 16'hBEEF);
    check("iso.rd_sel2", rb.rd_sel, 5'd4);
    set_in(16'h0004);
    do_press();

    // Scan mode walking across the 31 -> 0 wrap.
    regs[30] = 32'h0000001E;
    regs[31] = 32'hFFFF0001;
    regs[0]  = 32'h00000000;
    set_in(16'h801E);
    for (int k = 0; k < 6; k++) begin
      do_press();
      check($sformatf("scan%0d.out", k), out, scan_out[k]);
      check($sformatf("scan%0d.rd_sel", k), rb.rd_sel, scan_sel[k]);
      check($sformatf("scan%0d.hi_half", k), hi_half, scan_hi[k]);
    end

    // Reset in the middle of the high-half display.
    do_reset(16'h0007);

    // Randomized presses against the model.
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    scan_cnt = 0;
    for (int it = 0; it < 30; it++) begin
      if (m_phase == 0) begin
        set_in({1'($urandom_range(0, 3) == 0), 10'($urandom), 5'($urandom)});
        repeat (2) @(negedge clk);
        check_model($sformatf("rnd%0d.echo", it));
      end else begin
        if ($urandom_range(0, 1) == 1) set_in(16'($urandom));
        if ($urandom_range(0, 1) == 1) regs[m_addr] = $urandom;
        @(negedge clk);
      end
      do_press();
      check_model($sformatf("rnd%0d", it));
      if (m_scan) begin
        scan_cnt++;
        if (scan_cnt > 4) begin
          do_reset(16'($urandom));
          scan_cnt = 0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
